add_sub_seq: RTL and testbench
==============================

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  asynchronous active-high reset.
REQ-004 Port start  input  1  request; accepted on a rising edge where start=1 and ready=1.
REQ-005 Port sub  input  1  operation select, 0 = a+b, 1 = a-b; sampled at acceptance.
REQ-006 Port a  input  32  first operand; sampled at acceptance.
REQ-007 Port b  input  32  second operand; sampled at acceptance.
REQ-008 Port ready  output  1  high only in IDLE.
REQ-009 Port busy  output  1  high in RUN and DONE.
REQ-010 Port done  output  1  one-cycle pulse, high only in DONE.
REQ-011 Port result  output  32  final sum/difference, registered.
REQ-012 Port cout  output  1  add: carry out of bit 31; sub: borrow (unsigned a<b).
REQ-013 Port overflow  output  1  signed two's-complement overflow.
REQ-014 Port zero  output  1  result == 0.
REQ-015 Port negative  output  1  result[31].

Function
REQ-016 The block SHALL compute a 32-bit add/sub one byte per cycle with a single internal 8-bit adder that has a carry-in.
REQ-017 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-018 The transitions SHALL be: IDLE -> RUN on acceptance; RUN -> DONE on the edge that processes byte 3; DONE -> IDLE unconditionally on the next edge.
REQ-019 At acceptance the block SHALL latch a, b and sub, clear the byte index to 0 and load the carry register with sub.
REQ-020 Input changes after acceptance SHALL have no effect.
REQ-021 Each RUN edge SHALL compute {c, r} = a_byte + (sub ? ~b_byte : b_byte) + carry for byte[idx], write r into working-register byte idx, load c into carry, and increment idx (2-bit).
REQ-022 Byte order SHALL be byte 0 (bits 7:0) first, then byte 3 (bits 31:24) last.
REQ-023 On the RUN->DONE edge the block SHALL load result from the working register (including byte 3) and register all flags.
REQ-024 Flag cout SHALL be final carry when sub=0 and the inverse of final carry when sub=1.
REQ-025 Flag overflow SHALL be (a31==b31)&(r31^a31) when sub=0 and (a31^b31)&(r31^a31) when sub=1.
REQ-026 Latency: if acceptance is at edge E0, done SHALL be high for exactly the cycle after edge E4, and ready SHALL return high after edge E5.
REQ-027 result and the flags SHALL be valid from the done cycle and SHALL hold until the next DONE update, including across the next operation's RUN phase.
REQ-028 A start while busy=1 SHALL be ignored (not queued).
REQ-029 start held high continuously SHALL be accepted once per 6-cycle operation, at each edge where ready=1.
REQ-030 All arithmetic SHALL be modulo 2^32; carry out of bit 31 SHALL be reported only via cout.

Reset
REQ-031 On rst=1 the block SHALL, asynchronously, force state to IDLE and clear idx, carry, working register, result, cout, overflow, zero and negative to 0.
REQ-032 During and after reset, ready SHALL be 1, busy 0 and done 0.
REQ-033 Reset mid-RUN SHALL abort the operation, produce no done pulse and leave the block accepting on the first edge after rst deasserts.

Verification
REQ-034 Scenario: add 0x000000FF + 0x00000001 -> result 0x00000100, cout 0, overflow 0, zero 0, negative 0; done exactly in the cycle after E4.
REQ-035 Scenario: add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout 1, zero 1, overflow 0.
REQ-036 Scenario: sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, cout 1 (borrow), negative 1, overflow 0.
REQ-037 Scenario: add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, negative 1, cout 0; then sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1, cout 0.
REQ-038 Scenario: start pulsed with a=0x12345678 during RUN of 0x10 + 0x20 -> result 0x00000030, and exactly one done pulse.
REQ-039 Scenario: rst asserted two cycles into RUN -> all outputs 0, ready 1, no done; then sub 0x00000005 - 0x00000005 -> result 0, zero 1, cout 0.

Source files
------------

// File: rtl/add_sub_seq.sv
// Sequential 32-bit add/subtract using one 8-bit adder, one byte per cycle (LSB first).
// Latency: accept at E0, done pulses after E4, ready again after E5; start while busy is dropped.
module add_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        cout,
  output logic        overflow,
  output logic        zero,
  output logic        negative
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [31:0] wr_q, wr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic [31:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        overflow_q, overflow_d;
  logic        zero_q, zero_d;
  logic        negative_q, negative_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [8:0]  sum;

  // The single shared byte adder; subtraction is a + ~b + 1 with the 1 preloaded into carry.
  always_comb begin
    a_byte = a_q[idx_q*8 +: 8];
    b_byte = b_q[idx_q*8 +: 8];
    sum    = {1'b0, a_byte} + {1'b0, (sub_q ? ~b_byte : b_byte)} + {8'b0, carry_q};
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    wr_d       = wr_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = 2'd0;
          carry_d = sub;
          state_d = RUN;
        end
      end
      RUN: begin
        wr_d[idx_q*8 +: 8] = sum[7:0];
        carry_d = sum[8];
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d    = DONE;
          result_d   = {sum[7:0], wr_q[23:0]};
          cout_d     = sub_q ? ~sum[8] : sum[8];
          overflow_d = sub_q ? ((a_q[31] ^ b_q[31]) & (sum[7] ^ a_q[31]))
                             : (~(a_q[31] ^ b_q[31]) & (sum[7] ^ a_q[31]));
          zero_d     = (result_d == 32'd0);
          negative_d = sum[7];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      carry_q    <= 1'b0;
      wr_q       <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      sub_q      <= 1'b0;
      result_q   <= 32'd0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      wr_q       <= wr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq: vector table plus hand-written reset, ignored-start and held-start sequences.
module tb_add_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready, busy, done;
  logic [31:0] result;
  logic        cout, overflow, zero, negative;

  add_sub_seq dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    exp_t        e;
  } vec_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [31:0] last_res = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Independent reference using wide arithmetic rather than byte slicing.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t        e;
    logic [32:0] w;
    if (s) begin
      e.res = x - y;
      e.c   = (x < y);
      e.v   = (x[31] != y[31]) && (e.res[31] != x[31]);
    end else begin
      w     = {1'b0, x} + {1'b0, y};
      e.res = w[31:0];
      e.c   = w[32];
      e.v   = (x[31] == y[31]) && (e.res[31] != x[31]);
    end
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected record.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",   result,          e.res);
        chk("cout",     {31'd0, cout},     {31'd0, e.c});
        chk("overflow", {31'd0, overflow}, {31'd0, e.v});
        chk("zero",     {31'd0, zero},     {31'd0, e.z});
        chk("negative", {31'd0, negative}, {31'd0, e.n});
      end
    end
  end

  task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic sub_i,
                        input exp_t e, input bit poke);
    int n;
    int d0;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    d0 = done_cnt;
    start = 1'b1; a = a_i; b = b_i; sub = sub_i;
    sb.push_back(e);
    tick();
    // Scramble inputs after acceptance; they must not matter.
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(1));
    chk("busy_in_run",  {31'd0, busy},  32'd1);
    chk("ready_in_run", {31'd0, ready}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      if (poke && k == 2) begin
        start = 1'b1; a = 32'h12345678;
      end
      tick();
      if (poke && k == 2) start = 1'b0;
      if (k == 3) chk("result_hold_in_run", result, last_res);
      if (k < 5)  chk("no_early_done", done_cnt - d0, 0);
    end
    chk("done_latency", {31'd0, done}, 32'd1);
    chk("done_count",   done_cnt - d0, 1);
    tick();
    chk("done_one_cycle", {31'd0, done},  32'd0);
    chk("ready_after_e5", {31'd0, ready}, 32'd1);
    last_res = e.res;
  endtask

  vec_t vecs[10];

  initial begin
    int d0;
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{32'h00000000, 32'h00000001, 1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[5] = '{32'h00000005, 32'h00000005, 1'b1, '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[7] = '{32'h12345678, 32'h12345679, 1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, '{32'h01000100, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, '{32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0}};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 32'd0; b = 32'd0;
    tick();
    tick();
    chk("rst_ready",  {31'd0, ready},  32'd1);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_result", result,          32'd0);
    chk("rst_flags",  {28'd0, cout, overflow, zero, negative}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
      run_op(ra, rb, rs, model(ra, rb, rs), 1'b0);
    end

    // Start pulse mid-RUN must be dropped.
    run_op(32'h00000010, 32'h00000020, 1'b0, '{32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    d0 = done_cnt;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("ignored_start_no_done", done_cnt - d0, 0);

    // Reset two cycles into RUN aborts without a done pulse.
    d0 = done_cnt;
    start = 1'b1; a = 32'h11111111; b = 32'h22222222; sub = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrun_rst_result", result, 32'd0);
    chk("midrun_rst_flags",  {28'd0, cout, overflow, zero, negative}, 32'd0);
    chk("midrun_rst_ready",  {31'd0, ready}, 32'd1);
    chk("midrun_rst_busy",   {31'd0, busy},  32'd0);
    chk("midrun_rst_done",   {31'd0, done},  32'd0);
    tick(); tick();
    chk("midrun_rst_no_done", done_cnt - d0, 0);
    rst = 1'b0;
    last_res = 32'd0;
    run_op(32'h00000005, 32'h00000005, 1'b1, '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0);

    // start held high: accepted at E0 and E6 only (dropped before E12).
    d0 = done_cnt;
    start = 1'b1; a = 32'h00000003; b = 32'h00000004; sub = 1'b0;
    sb.push_back(model(32'h3, 32'h4, 1'b0));
    sb.push_back(model(32'h3, 32'h4, 1'b0));
    for (int k = 0; k < 11; k++) tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("held_start_two_ops", done_cnt - d0, 2);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
